// File: rtl/vec_cache_us_req_master_arb.sv
// Round-robin arbiter from N upstream masters onto M registered cache lanes.
// Each lane is a one-deep slot; free lanes are handed out lowest-index first.

package vector_cache_pkg;
  localparam int MID_W = 4;

  typedef struct packed {
    logic [MID_W-1:0] master_id;
    logic [7:0]       seq;
  } txn_id_t;

  typedef struct packed {
    txn_id_t     txn_id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } us_data_pld_t;
endpackage

module vec_cache_us_req_master_arb
  import vector_cache_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_vld,
  input  us_data_pld_t in_pld [N],
  output logic [N-1:0] in_rdy,
  output logic [M-1:0] out_vld,
  output us_data_pld_t out_pld [M],
  input  logic [M-1:0] out_rdy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (M > 1) ? $clog2(M) : 1;

  logic [M-1:0]  vld_q, vld_d;
  us_data_pld_t  pld_q [M];
  us_data_pld_t  pld_d [M];
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]  rdy;

  // Scan masters from rr_ptr, handing each requester the lowest free lane.
  always_comb begin
    logic [M-1:0]  avail;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [LW-1:0] lane;
    logic [PW-1:0] last;
    logic          any;
    us_data_pld_t  p;
    avail = ~vld_q | out_rdy;
    vld_d = vld_q & ~out_rdy;
    for (int i = 0; i < M; i++) begin
      pld_d[i] = pld_q[i];
    end
    rdy  = '0;
    sum  = '0;
    idx  = '0;
    lane = '0;
    last = '0;
    any  = 1'b0;
    p    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (in_vld[idx] && (avail != '0) && !rst) begin
        lane = '0;
        for (int i = M-1; i >= 0; i--) begin
          if (avail[i]) lane = LW'(i);
        end
        p = in_pld[idx];
        p.txn_id.master_id = MID_W'(idx);
        pld_d[lane] = p;
        vld_d[lane] = 1'b1;
        avail[lane] = 1'b0;
        rdy[idx]    = 1'b1;
        last        = idx;
        any         = 1'b1;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any) begin
      if ({1'b0, last} == (PW+1)'(N-1)) rr_ptr_d = '0;
      else rr_ptr_d = last + PW'(1);
    end
  end

  // Lane slots and round-robin pointer; reset discards all lane contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < M; i++) begin
        pld_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < M; i++) begin
        pld_q[i] <= pld_d[i];
      end
    end
  end

  // Outputs come straight from the lane registers.
  always_comb begin
    in_rdy  = rdy;
    out_vld = vld_q;
    for (int i = 0; i < M; i++) begin
      out_pld[i] = pld_q[i];
    end
  end

endmodule

// File: tb/tb_vec_cache_us_req_master_arb.sv
// Directed bench for the master arbiter at M=2, N=4.
// Grants are predicted per step; a per-lane scoreboard checks lane output.

module tb_vec_cache_us_req_master_arb;
  import vector_cache_pkg::*;

  logic         clk;
  logic         rst;
  logic [3:0]   in_vld;
  us_data_pld_t in_pld [4];
  logic [3:0]   in_rdy;
  logic [1:0]   out_vld;
  us_data_pld_t out_pld [2];
  logic [1:0]   out_rdy;

  int tests;
  int fails;

  us_data_pld_t sq0[$];
  us_data_pld_t sq1[$];
  us_data_pld_t snap0, snap1;

  vec_cache_us_req_master_arb #(.M(2), .N(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_pld  (in_pld),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_pld (out_pld),
    .out_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_pld();
    for (int j = 0; j < 4; j++) begin
      in_pld[j].txn_id.master_id = 4'($urandom);
      in_pld[j].txn_id.seq       = 8'($urandom);
      in_pld[j].wr               = 1'($urandom);
      in_pld[j].addr             = $urandom;
      in_pld[j].data             = $urandom;
    end
  endtask

  function automatic us_data_pld_t expect_pld(input int j);
    us_data_pld_t p;
    p = in_pld[j];
    p.txn_id.master_id = 4'(j);
    return p;
  endfunction

  // One cycle: drive, check in_rdy, score pops, push predicted grants.
  task automatic step(input logic [3:0] v, input logic [1:0] ordy,
                      input logic [3:0] exp_rdy, input int g0, input int g1);
    us_data_pld_t e;
    in_vld  = v;
    out_rdy = ordy;
    rand_pld();
    #1;
    chk("in_rdy", 128'(in_rdy), 128'(exp_rdy));
    if (out_vld[0] && out_rdy[0]) begin
      if (sq0.size() == 0) chk("sb_lane0_empty", 128'(1), 128'(0));
      else begin
        e = sq0.pop_front();
        chk("out_pld0", 128'(out_pld[0]), 128'(e));
      end
    end
    if (out_vld[1] && out_rdy[1]) begin
      if (sq1.size() == 0) chk("sb_lane1_empty", 128'(1), 128'(0));
      else begin
        e = sq1.pop_front();
        chk("out_pld1", 128'(out_pld[1]), 128'(e));
      end
    end
    if (g0 >= 0) sq0.push_back(expect_pld(g0));
    if (g1 >= 0) sq1.push_back(expect_pld(g1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    in_vld  = '0;
    out_rdy = '0;
    rand_pld();
    #2;
    chk("reset_out_vld", 128'(out_vld), 128'(0));
    chk("reset_out_pld0", 128'(out_pld[0]), 128'(0));
    chk("reset_in_rdy", 128'(in_rdy), 128'(0));
    in_vld = 4'b1111;
    #1;
    chk("reset_in_rdy_vld", 128'(in_rdy), 128'(0));
    in_vld = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single request from master 2
    step(4'b0100, 2'b00, 4'b0100, 2, -1);
    chk("single_out_vld", 128'(out_vld), 128'(2'b01));
    chk("single_mid", 128'(out_pld[0].txn_id.master_id), 128'(2));

    // rr_ptr=3: wrap-around, lane 0 pops and refills
    step(4'b1001, 2'b01, 4'b1001, 3, 0);
    chk("wrap_out_vld", 128'(out_vld), 128'(2'b11));
    chk("wrap_mid0", 128'(out_pld[0].txn_id.master_id), 128'(3));
    chk("wrap_mid1", 128'(out_pld[1].txn_id.master_id), 128'(0));

    // backpressure: full lanes, no pops
    snap0 = out_pld[0];
    snap1 = out_pld[1];
    for (int c = 0; c < 5; c++) begin
      step(4'b0001, 2'b00, 4'b0000, -1, -1);
      chk("bp_vld", 128'(out_vld), 128'(2'b11));
      chk("bp_hold0", 128'(out_pld[0]), 128'(snap0));
      chk("bp_hold1", 128'(out_pld[1]), 128'(snap1));
    end
    step(4'b0001, 2'b10, 4'b0001, -1, 0);
    step(4'b0000, 2'b11, 4'b0000, -1, -1);
    chk("drain1_vld", 128'(out_vld), 128'(0));

    // master_id overwrite (rr_ptr=1)
    step(4'b0010, 2'b00, 4'b0010, 1, -1);
    chk("ovr_mid", 128'(out_pld[0].txn_id.master_id), 128'(1));
    step(4'b0000, 2'b11, 4'b0000, -1, -1);

    // bring rr_ptr to 0 via master 3
    step(4'b1000, 2'b00, 4'b1000, 3, -1);
    step(4'b0000, 2'b01, 4'b0000, -1, -1);

    // oversubscription
    step(4'b1111, 2'b11, 4'b0011, 0, 1);
    step(4'b1111, 2'b11, 4'b1100, 2, 3);
    step(4'b1111, 2'b11, 4'b0011, 0, 1);
    step(4'b0000, 2'b11, 4'b0000, -1, -1);
    chk("drain2_vld", 128'(out_vld), 128'(0));

    // reset mid-traffic (rr_ptr=2)
    step(4'b0011, 2'b00, 4'b0011, 0, 1);
    chk("pre_rst_vld", 128'(out_vld), 128'(2'b11));
    in_vld = 4'b1111;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_vld", 128'(out_vld), 128'(0));
    chk("async_rst_rdy", 128'(in_rdy), 128'(0));
    sq0.delete();
    sq1.delete();
    in_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1010, 2'b00, 4'b1010, 1, 3);
    chk("post_rst_mid0", 128'(out_pld[0].txn_id.master_id), 128'(1));
    chk("post_rst_mid1", 128'(out_pld[1].txn_id.master_id), 128'(3));
    step(4'b0000, 2'b11, 4'b0000, -1, -1);

    chk("sb_left0", 128'(sq0.size()), 128'(0));
    chk("sb_left1", 128'(sq1.size()), 128'(0));
    chk("final_vld", 128'(out_vld), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_cache_us_req_master_arb.md
VEC_CACHE_US_REQ_MASTER_ARB -- requirements
Module: vec_cache_us_req_master_arb

Interface
REQ-001 SHALL import vector_cache_pkg.
REQ-002 SHALL have parameter M, default 8, meaning number of output lanes toward the cache.
REQ-003 SHALL have parameter N, default 16, meaning number of upstream masters; N >= M >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_vld  input  N  per-master request valid.
REQ-007 SHALL have port in_pld  input  us_data_pld_t [N]  per-master payload.
REQ-008 SHALL have port in_rdy  output  N  per-master accept; a transfer occurs when in_vld[j] and in_rdy[j] are both high.
REQ-009 SHALL have port out_vld  output  M  per-lane valid, driven directly from a lane register.
REQ-010 SHALL have port out_pld  output  us_data_pld_t [M]  per-lane payload, driven directly from a lane register.
REQ-011 SHALL have port out_rdy  input  M  per-lane downstream accept.

Function
REQ-012 SHALL hold one register slot per lane (valid bit plus payload); out_vld/out_pld reflect the slot contents.
REQ-013 SHALL treat lane i as free in a cycle when slot i is empty, or when out_vld[i] and out_rdy[i] are both high (same-cycle pop and refill allowed).
REQ-014 SHALL keep a round-robin pointer rr_ptr of width $clog2(N); the reset value is 0.
REQ-015 SHALL scan masters in order rr_ptr, rr_ptr+1, ... modulo N; each requesting master is granted the lowest-index free lane not yet assigned this cycle, until free lanes run out.
REQ-016 SHALL grant each master at most once per cycle and place at most one payload in each lane per cycle.
REQ-017 SHALL assert in_rdy[j] combinationally, exactly when master j is granted; in_rdy[j] SHALL be 0 whenever in_vld[j] is 0.
REQ-018 SHALL load the granted lane slot on the next edge with in_pld[j], with txn_id.master_id overwritten by j truncated to $clog2(N) bits; all other fields pass unchanged.
REQ-019 SHALL give a latency of 1 cycle: a request accepted in cycle t appears on out_vld/out_pld in cycle t+1.
REQ-020 SHALL hold the slot stable (valid and payload unchanged) while out_vld is high and out_rdy is low.
REQ-021 SHALL clear the slot on out_vld & out_rdy unless it is refilled in the same cycle.
REQ-022 SHALL update rr_ptr to (last granted master index + 1) mod N when at least one grant occurs; otherwise rr_ptr holds.
REQ-023 SHALL, when all lanes are full and none is popping, grant no master; all in_rdy are 0 and rr_ptr holds.
REQ-024 SHALL ensure no request is dropped or duplicated: every in handshake yields exactly one out handshake.
REQ-025 SHALL preserve per-master order across lanes: a master's request accepted in a later cycle never leaves before an earlier one when all lanes pop in lane-index order; no ordering is guaranteed across lanes otherwise.

Reset
REQ-026 SHALL, on rst high (asynchronous), clear all out_vld to 0, all out_pld to '0, and rr_ptr to 0; in_rdy is 0 while rst is high.
REQ-027 SHALL, when reset is asserted mid-operation, discard slot contents; the first grant after deassertion starts scanning from master 0.

Verification
REQ-028 SHALL cover single request (M=2, N=4): in_vld=4'b0100, all lanes empty -> in_rdy=4'b0100; next cycle out_vld=2'b01, out_pld[0].txn_id.master_id=2; rr_ptr=3.
REQ-029 SHALL cover oversubscription: M=2, N=4, rr_ptr=0, in_vld=4'b1111, lanes empty, out_rdy=2'b11 -> cycle 0 grants masters 0,1; cycle 1 grants masters 2,3; cycle 2 grants masters 0,1.
REQ-030 SHALL cover backpressure: both lanes full, out_rdy=0, in_vld=4'b0001 for 5 cycles -> in_rdy=0 throughout, out_pld unchanged; out_rdy[1]=1 -> master 0 is granted lane 1 that same cycle.
REQ-031 SHALL cover wrap-around: rr_ptr=3, in_vld=4'b1001 -> master 3 is granted lane 0 and master 0 is granted lane 1; rr_ptr becomes 1.
REQ-032 SHALL cover master_id overwrite: master 1 drives txn_id.master_id=3 -> output shows 1; other payload fields bit-identical.
REQ-033 SHALL cover reset mid-traffic: rst pulsed while out_vld=2'b11 -> out_vld=0 immediately (asynchronous); after release, in_vld=4'b1010 grants master 1 to lane 0 and master 3 to lane 1.
